// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access unit.
// Decodes the load/store held in EXE_MEM, runs one req/ack transaction with
// data memory while stalling the pipeline, and aligns/extends load data for
// the EXE-stage load-to-ALU bypass.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_ena,
    input  logic [31:0]       mem_instr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_store_data,
    output logic              dm_req,
    output logic              dm_we,
    output logic [3:0]        dm_be,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    input  logic              dm_ack,
    input  logic [31:0]       dm_rdata,
    output logic [31:0]       mem_load_data,
    output logic              mem_stall,
    output logic              mem_addr_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    logic [1:0]  state;
    logic [5:0]  opcode;
    logic [5:0]  ld_op;        // opcode of the access in flight
    logic [1:0]  ld_k;         // byte offset of the access in flight
    logic        is_access;
    logic        is_store;
    logic        is_half;
    logic        is_word;
    logic        aligned;
    logic        start;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_result;

    assign opcode = mem_instr[31:26];

    // The instruction's immediate/register fields are not needed here.
    logic unused_instr_bits;
    assign unused_instr_bits = &{1'b0, mem_instr[25:0]};

    // Classify the opcode in MEM by access kind and size.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        is_access = 1'b0;
        is_store  = 1'b0;
        is_half   = 1'b0;
        is_word   = 1'b0;
        case (opcode)
            OP_LB, OP_LBU: is_access = 1'b1;
            OP_LH, OP_LHU: begin is_access = 1'b1; is_half = 1'b1; end
            OP_LW:         begin is_access = 1'b1; is_word = 1'b1; end
            OP_SB:         begin is_access = 1'b1; is_store = 1'b1; end
            OP_SH:         begin is_access = 1'b1; is_store = 1'b1; is_half = 1'b1; end
            OP_SW:         begin is_access = 1'b1; is_store = 1'b1; is_word = 1'b1; end
            default:       ;
        endcase
    end

    assign aligned = !((is_half && mem_addr[0]) || (is_word && (mem_addr[1:0] != 2'b00)));
    assign start   = mem_ena && is_access && aligned;

    // Store lane enables and lane-replicated write data; loads read the full word.
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = 32'h0;
        case (opcode)
            OP_SB: begin
                be_next    = 4'b0001 << mem_addr[1:0];
                wdata_next = {4{mem_store_data[7:0]}};
            end
            OP_SH: begin
                be_next    = 4'b0011 << {mem_addr[1], 1'b0};
                wdata_next = {2{mem_store_data[15:0]}};
            end
            OP_SW:   wdata_next = mem_store_data;
            default: ;
        endcase
    end

    // Pick the addressed byte/halfword out of the returned word and extend it.
    always_comb begin
        case (ld_k)
            2'd0:    ld_byte = dm_rdata[7:0];
            2'd1:    ld_byte = dm_rdata[15:8];
            2'd2:    ld_byte = dm_rdata[23:16];
            default: ld_byte = dm_rdata[31:24];
        endcase
        ld_half = ld_k[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (ld_op)
            OP_LB:   load_result = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  load_result = {24'h0, ld_byte};
            OP_LH:   load_result = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  load_result = {16'h0, ld_half};
            default: load_result = dm_rdata;
        endcase
    end

    // Stall covers the issuing IDLE cycle and every BUSY cycle, never DONE.
    assign mem_stall    = ((state == ST_IDLE) && start) || (state == ST_BUSY);
    assign mem_addr_err = (state == ST_IDLE) && mem_ena && is_access && !aligned;

    // Access FSM: latch the request at start, hold it until ack, then one DONE cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            state         <= ST_IDLE;
            dm_req        <= 1'b0;
            dm_we         <= 1'b0;
            dm_be         <= 4'b0000;
            dm_addr       <= '0;
            dm_wdata      <= 32'h0;
            mem_load_data <= 32'h0;
            ld_op         <= 6'b0;
            ld_k          <= 2'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_BUSY;
                        dm_req   <= 1'b1;
                        dm_we    <= is_store;
                        dm_be    <= be_next;
                        dm_addr  <= {mem_addr[ADDR_W-1:2], 2'b00};
                        dm_wdata <= wdata_next;
                        ld_op    <= opcode;
                        ld_k     <= mem_addr[1:0];
                    end
                end
                ST_BUSY: begin
                    if (dm_ack) begin
                        dm_req <= 1'b0;
                        state  <= ST_DONE;
                        if (!dm_we) begin
                            mem_load_data <= load_result;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized checks of mem_access_unit
// against a behavioural model of the load/store rules.
module tb_mem_access_unit;

    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_LH   = 6'b100001;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_LBU  = 6'b100100;
    localparam logic [5:0] OP_LHU  = 6'b100101;
    localparam logic [5:0] OP_SB   = 6'b101000;
    localparam logic [5:0] OP_SH   = 6'b101001;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDU = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    logic        clk;
    logic        rst_n;
    logic        mem_ena;
    logic [31:0] mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_store_data;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic [31:0] mem_load_data;
    logic        mem_stall;
    logic        mem_addr_err;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] model_load = 32'h0;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_ena        (mem_ena),
        .mem_instr      (mem_instr),
        .mem_addr       (mem_addr),
        .mem_store_data (mem_store_data),
        .dm_req         (dm_req),
        .dm_we          (dm_we),
        .dm_be          (dm_be),
        .dm_addr        (dm_addr),
        .dm_wdata       (dm_wdata),
        .dm_ack         (dm_ack),
        .dm_rdata       (dm_rdata),
        .mem_load_data  (mem_load_data),
        .mem_stall      (mem_stall),
        .mem_addr_err   (mem_addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural reference ----------------
    function automatic bit op_is_load(input logic [5:0] op);
        return op == OP_LB || op == OP_LH || op == OP_LW || op == OP_LBU || op == OP_LHU;
    endfunction

    function automatic bit op_is_store(input logic [5:0] op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    // Access size in bytes.
    function automatic int op_size(input logic [5:0] op);
        if (op == OP_LW || op == OP_SW) return 4;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int sz;
        int v;
        logic [31:0] shifted;
        sz = op_size(op);
        if (sz == 4) return rdata;
        shifted = rdata >> (8 * int'(addr % sz == 0 ? addr % 4 : 0));
        if (sz == 1) begin
            v = int'(shifted & 32'hFF);
            if (op == OP_LB && v > 127) v -= 256;
        end else begin
            v = int'(shifted & 32'hFFFF);
            if (op == OP_LH && v > 32767) v -= 65536;
        end
        return 32'(v);
    endfunction

    function automatic logic [31:0] ref_be(input logic [5:0] op, input logic [31:0] addr);
        int sz;
        if (!op_is_store(op)) return 32'hF;
        sz = op_size(op);
        return 32'(((1 << sz) - 1) << int'(addr % 4));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [5:0] op, input logic [31:0] rt);
        if (op == OP_SB) return (rt & 32'hFF) * 32'h01010101;
        if (op == OP_SH) return (rt & 32'hFFFF) * 32'h00010001;
        return rt;
    endfunction

    // ---------------- one pipeline instruction in MEM ----------------
    // waits = BUSY cycles without ack before the acking BUSY cycle.
    task automatic run_op(input logic [5:0] op, input bit ena, input logic [31:0] addr,
                          input logic [31:0] rt, input logic [31:0] rdata, input int waits);
        bit access;
        bit aligned;
        int stalls;
        access  = op_is_load(op) || op_is_store(op);
        aligned = (addr % op_size(op)) == 0;

        @(negedge clk);
        mem_ena        = ena;
        mem_instr      = {op, 26'($urandom)};
        mem_addr       = addr;
        mem_store_data = rt;
        dm_ack         = 1'b0;
        dm_rdata       = $urandom;

        if (!(ena && access && aligned)) begin
            // Stray ack while idle must be ignored.
            dm_ack = $urandom_range(0, 1) != 0;
            #1;
            check("noacc_stall", 32'(mem_stall), 32'(0));
            check("noacc_req", 32'(dm_req), 32'(0));
            check("noacc_err", 32'(mem_addr_err), 32'(ena && access && !aligned));
            @(posedge clk);
            @(negedge clk);
            mem_ena = 1'b0;
            dm_ack  = 1'b0;
            #1;
            check("noacc_err_gone", 32'(mem_addr_err), 32'(0));
            check("noacc_req_after", 32'(dm_req), 32'(0));
            check("noacc_load_kept", mem_load_data, model_load);
            return;
        end

        // Issuing IDLE cycle.
        #1;
        check("c0_stall", 32'(mem_stall), 32'(1));
        check("c0_err", 32'(mem_addr_err), 32'(0));
        check("c0_req", 32'(dm_req), 32'(0));
        check("c0_load_kept", mem_load_data, model_load);
        stalls = 1;
        @(posedge clk);

        for (int w = 0; w <= waits; w++) begin
            @(negedge clk);
            dm_ack   = (w == waits);
            dm_rdata = (w == waits) ? rdata : 32'($urandom);
            #1;
            check("busy_req", 32'(dm_req), 32'(1));
            if (w == 0) begin
                check("bus_we", 32'(dm_we), 32'(op_is_store(op)));
                check("bus_be", 32'(dm_be), ref_be(op, addr));
                check("bus_addr", dm_addr, addr & ~32'h3);
                if (op_is_store(op)) check("bus_wdata", dm_wdata, ref_wdata(op, rt));
            end
            if (mem_stall) stalls++;
            @(posedge clk);
        end

        if (op_is_load(op)) model_load = ref_load(op, addr, rdata);

        // DONE cycle: a stray ack here must be ignored too.
        @(negedge clk);
        dm_ack   = $urandom_range(0, 1) != 0;
        dm_rdata = $urandom;
        #1;
        check("done_stall", 32'(mem_stall), 32'(0));
        check("done_req", 32'(dm_req), 32'(0));
        check("done_load", mem_load_data, model_load);
        check("stall_cycles", 32'(stalls), 32'(waits + 2));
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        mem_ena = 1'b0;
        dm_ack  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_load = 32'h0;
    endtask

    initial begin
        logic [5:0] ops [10];
        ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW, OP_ADDU, OP_ADDI};
        rst_n = 1'b1; mem_ena = 1'b0; mem_instr = 32'h0; mem_addr = 32'h0;
        mem_store_data = 32'h0; dm_ack = 1'b0; dm_rdata = 32'h0;

        // Reset state.
        do_reset();
        #1;
        check("rst_req", 32'(dm_req), 32'(0));
        check("rst_we", 32'(dm_we), 32'(0));
        check("rst_be", 32'(dm_be), 32'(0));
        check("rst_addr", dm_addr, 32'h0);
        check("rst_wdata", dm_wdata, 32'h0);
        check("rst_load", mem_load_data, 32'h0);
        check("rst_stall", 32'(mem_stall), 32'(0));
        check("rst_err", 32'(mem_addr_err), 32'(0));

        // Directed scenarios.
        run_op(OP_LW,  1'b1, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        run_op(OP_LB,  1'b1, 32'h103, 32'h0, 32'h80FF7F01, 2);
        run_op(OP_LBU, 1'b1, 32'h103, 32'h0, 32'h80FF7F01, 2);
        run_op(OP_SH,  1'b1, 32'h202, 32'h1234ABCD, 32'h0, 1);
        run_op(OP_LW,  1'b1, 32'h101, 32'h0, 32'h0, 0);
        run_op(OP_ADDU, 1'b1, 32'h100, 32'h0, 32'h0, 0);
        run_op(OP_LW,  1'b0, 32'h100, 32'h0, 32'h0, 0);
        run_op(OP_LH,  1'b1, 32'h102, 32'h0, 32'h8001FFFF, 0);
        run_op(OP_SB,  1'b1, 32'h301, 32'h000000A5, 32'h0, 0);

        // Reset during BUSY, then a late ack.
        @(negedge clk);
        mem_ena = 1'b1; mem_instr = {OP_LW, 26'h0}; mem_addr = 32'h400; dm_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rb_busy_req", 32'(dm_req), 32'(1));
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; mem_ena = 1'b0; dm_ack = 1'b1; dm_rdata = 32'hCAFEF00D;
        model_load = 32'h0;
        #1;
        check("rb_req", 32'(dm_req), 32'(0));
        check("rb_stall", 32'(mem_stall), 32'(0));
        check("rb_load", mem_load_data, 32'h0);
        @(posedge clk);
        @(negedge clk);
        dm_ack = 1'b0;
        #1;
        check("rb_late_ack_req", 32'(dm_req), 32'(0));
        check("rb_late_ack_load", mem_load_data, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            run_op(ops[$urandom_range(0, 9)], $urandom_range(0, 7) != 0,
                   {20'h0, 12'($urandom)}, $urandom, $urandom, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
